// File: rtl/frame_fetch_ctrl_if.sv
// Burst-read handshake between frame_fetch_ctrl and the PLB master read engine.
// One request is outstanding at most; rd_done closes the burst.
interface frame_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_len;
    logic              rd_ack;
    logic              rd_done;

    modport master (
        output rd_req, rd_addr, rd_len,
        input  rd_ack, rd_done
    );

    modport slave (
        input  rd_req, rd_addr, rd_len,
        output rd_ack, rd_done
    );
endinterface

// File: rtl/frame_fetch_ctrl.sv
// Frame-read address generator and burst scheduler for the HDMI output path.
// Walks a frame line by line in bursts of up to BURST_BYTES, gated by pixel FIFO room.
module frame_fetch_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int BURST_BYTES = 128,
    parameter int WORD_BYTES  = 4,
    parameter int FIFO_WORDS  = 512,
    parameter int LVL_W       = 10
) (
    input  logic              Bus2IP_Clk,
    input  logic              Bus2IP_Reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] frame_base0,
    input  logic [ADDR_W-1:0] frame_base1,
    input  logic              buf_sel,
    input  logic [ADDR_W-1:0] line_stride,
    input  logic [15:0]       line_bytes,
    input  logic [10:0]       num_lines,
    input  logic              frame_start,
    input  logic [LVL_W-1:0]  fifo_level,
    frame_fetch_ctrl_if.master rd,
    output logic              active_buf,
    output logic              frame_done,
    output logic              resync
);

    localparam int CW = LVL_W + 1;
    localparam logic [15:0]   BURST_L = 16'(BURST_BYTES);
    localparam logic [15:0]   WORD_L  = 16'(WORD_BYTES);
    localparam logic [CW-1:0] FIFO_L  = CW'(FIFO_WORDS);

    typedef enum logic [2:0] {
        IDLE, ARMED, CHECK, REQ, WAIT, ADVANCE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] line_addr, line_addr_nxt;
    logic [15:0]       offset, offset_nxt;
    logic [10:0]       line_cnt, line_nxt;
    logic              abuf_nxt, resync_nxt;
    logic              pend, pend_nxt;
    logic              halt, halt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [15:0]       len_q, len_nxt;
    logic              relatch;

    logic [15:0]       rem_bytes, len_next, len_words, off_sum;
    logic [CW-1:0]     lvl_sum;
    logic              room;
    logic [10:0]       line_inc;

    assign rem_bytes = line_bytes - offset;
    assign len_next  = (rem_bytes > BURST_L) ? BURST_L : rem_bytes;
    assign len_words = len_next / WORD_L;
    // One extra bit so a nearly-full FIFO plus a burst cannot wrap past the limit.
    assign lvl_sum   = {1'b0, fifo_level} + CW'(len_words);
    assign room      = (lvl_sum <= FIFO_L);
    assign off_sum   = offset + len_q;
    assign line_inc  = line_cnt + 11'd1;

    assign rd.rd_req  = (state == REQ);
    assign rd.rd_addr = addr_q;
    assign rd.rd_len  = len_q;

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state      <= IDLE;
            line_addr  <= '0;
            offset     <= '0;
            line_cnt   <= '0;
            active_buf <= 1'b0;
            resync     <= 1'b0;
            pend       <= 1'b0;
            halt       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
        end else begin
            state      <= state_nxt;
            line_addr  <= line_addr_nxt;
            offset     <= offset_nxt;
            line_cnt   <= line_nxt;
            active_buf <= abuf_nxt;
            resync     <= resync_nxt;
            pend       <= pend_nxt;
            halt       <= halt_nxt;
            addr_q     <= addr_nxt;
            len_q      <= len_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        line_addr_nxt = line_addr;
        offset_nxt    = offset;
        line_nxt      = line_cnt;
        abuf_nxt      = active_buf;
        resync_nxt    = resync;
        pend_nxt      = pend;
        halt_nxt      = halt;
        addr_nxt      = addr_q;
        len_nxt       = len_q;
        frame_done    = 1'b0;
        relatch       = 1'b0;

        unique case (state)
            IDLE: begin
                pend_nxt = 1'b0;
                halt_nxt = 1'b0;
                if (start && !stop) begin
                    state_nxt  = ARMED;
                    resync_nxt = 1'b0;
                end
            end
            ARMED: begin
                if (stop)
                    state_nxt = IDLE;
                else if (frame_start || pend)
                    relatch = 1'b1;
            end
            CHECK: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (frame_start || pend) begin
                    relatch = 1'b1;
                    if (frame_start)
                        resync_nxt = 1'b1;
                end else if (room) begin
                    state_nxt = REQ;
                    addr_nxt  = line_addr + ADDR_W'(offset);
                    len_nxt   = len_next;
                end
            end
            // The request is never withdrawn; stop/frame_start are remembered for later.
            REQ: begin
                if (stop)
                    halt_nxt = 1'b1;
                if (frame_start) begin
                    resync_nxt = 1'b1;
                    pend_nxt   = 1'b1;
                end
                if (rd.rd_ack)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (stop)
                    halt_nxt = 1'b1;
                if (frame_start) begin
                    resync_nxt = 1'b1;
                    pend_nxt   = 1'b1;
                end
                if (rd.rd_done) begin
                    if (halt || stop)
                        state_nxt = IDLE;
                    else if (pend || frame_start)
                        relatch = 1'b1;
                    else
                        state_nxt = ADVANCE;
                end
            end
            ADVANCE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (frame_start) begin
                    resync_nxt = 1'b1;
                    relatch    = 1'b1;
                end else if (off_sum == line_bytes) begin
                    offset_nxt    = '0;
                    line_addr_nxt = line_addr + line_stride;
                    line_nxt      = line_inc;
                    if (line_inc == num_lines) begin
                        frame_done = 1'b1;
                        state_nxt  = ARMED;
                    end else begin
                        state_nxt = CHECK;
                    end
                end else begin
                    offset_nxt = off_sum;
                    state_nxt  = CHECK;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Frame latch: buffer choice and base are frozen here for the whole frame.
        if (relatch) begin
            line_addr_nxt = buf_sel ? frame_base1 : frame_base0;
            abuf_nxt      = buf_sel;
            line_nxt      = '0;
            offset_nxt    = '0;
            pend_nxt      = 1'b0;
            state_nxt     = CHECK;
        end
    end

endmodule

// File: tb/tb_frame_fetch_ctrl.sv
// Self-checking bench for frame_fetch_ctrl: randomized frames against a burst-list model.
module tb_frame_fetch_ctrl;

    localparam int ADDR_W = 32;
    localparam int BURST  = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, buf_sel = 1'b0, frame_start = 1'b0;
    logic [31:0] base0 = '0, base1 = '0, stride = '0;
    logic [15:0] lbytes = 16'd4;
    logic [10:0] nlines = 11'd1;
    logic [9:0]  fifo_level = '0;
    logic        active_buf, frame_done, resync;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;

    always #5 clk = ~clk;

    frame_fetch_ctrl_if #(.ADDR_W(ADDR_W)) rd_if ();

    frame_fetch_ctrl #(
        .ADDR_W(ADDR_W), .BURST_BYTES(BURST), .WORD_BYTES(4), .FIFO_WORDS(512), .LVL_W(10)
    ) dut (
        .Bus2IP_Clk  (clk),
        .Bus2IP_Reset(rst),
        .start       (start),
        .stop        (stop),
        .frame_base0 (base0),
        .frame_base1 (base1),
        .buf_sel     (buf_sel),
        .line_stride (stride),
        .line_bytes  (lbytes),
        .num_lines   (nlines),
        .frame_start (frame_start),
        .fifo_level  (fifo_level),
        .rd          (rd_if),
        .active_buf  (active_buf),
        .frame_done  (frame_done),
        .resync      (resync)
    );

    always @(negedge clk) if (frame_done) fd_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rd_if.rd_req) begin
                got = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic serve(input int ack_dly, input int done_dly);
        repeat (ack_dly) tick();
        rd_if.rd_ack = 1'b1; tick(); rd_if.rd_ack = 1'b0;
        repeat (done_dly) tick();
        rd_if.rd_done = 1'b1; tick(); rd_if.rd_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (rd_if.rd_req !== 1'b0) begin bad++; $display("FAIL reset_rd_req: got %b want 0", rd_if.rd_req); end
        total++; if (rd_if.rd_addr !== 32'h0) begin bad++; $display("FAIL reset_rd_addr: got %h want 0", rd_if.rd_addr); end
        total++; if (rd_if.rd_len !== 16'h0) begin bad++; $display("FAIL reset_rd_len: got %h want 0", rd_if.rd_len); end
        total++; if (active_buf !== 1'b0) begin bad++; $display("FAIL reset_active_buf: got %b want 0", active_buf); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        total++; if (resync !== 1'b0) begin bad++; $display("FAIL reset_resync: got %b want 0", resync); end
        rst = 1'b0;
        tick();
    endtask

    // One full frame from ARMED, every burst compared with the model's burst list.
    task automatic test_frame(input logic [31:0] b, input logic [31:0] st, input logic [15:0] lb,
                              input logic [10:0] nl, input logic sel, input int dmax);
        logic [31:0] qa[$];
        logic [15:0] ql[$];
        int  fd0;
        bit  got, seen;
        for (int l = 0; l < int'(nl); l++)
            for (int off = 0; off < int'(lb); off += BURST) begin
                qa.push_back(b + 32'(l) * st + 32'(off));
                ql.push_back(16'((int'(lb) - off > BURST) ? BURST : int'(lb) - off));
            end
        if (sel) begin base1 = b; base0 = ~b & 32'hFFFF_FFFC; end
        else     begin base0 = b; base1 = ~b & 32'hFFFF_FFFC; end
        buf_sel = sel; stride = st; lbytes = lb; nlines = nl; fifo_level = '0;
        fd0 = fd_cnt;
        pulse_fs();
        total++; if (rd_if.rd_req !== 1'b0) begin bad++; $display("FAIL frame_lat_check: rd_req %b want 0", rd_if.rd_req); end
        tick();
        total++; if (rd_if.rd_req !== 1'b1) begin bad++; $display("FAIL frame_lat_req: rd_req %b want 1", rd_if.rd_req); end
        for (int i = 0; i < qa.size(); i++) begin
            wait_req(64, got);
            total++;
            if (!got) begin bad++; $display("FAIL frame_req_timeout: burst %0d rd_req 0 want 1", i); return; end
            total++;
            if (rd_if.rd_addr !== qa[i] || rd_if.rd_len !== ql[i]) begin
                bad++;
                $display("FAIL frame_burst %0d: addr %h len %0d want addr %h len %0d",
                         i, rd_if.rd_addr, rd_if.rd_len, qa[i], ql[i]);
            end
            serve($urandom_range(0, dmax), $urandom_range(0, dmax));
        end
        tick(); tick();
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt - fd0); end
        total++; if (active_buf !== sel) begin bad++; $display("FAIL frame_active_buf: got %b want %b", active_buf, sel); end
        seen = 1'b0;
        repeat (8) begin tick(); if (rd_if.rd_req) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL frame_extra_req: rd_req seen %b want 0", seen); end
    endtask

    task automatic test_720p();
        test_frame(32'hA800_0000, 32'd5120, 16'd5120, 11'd8, 1'b0, 0);
    endtask

    task automatic test_tail();
        test_frame(32'h1000_0000, 32'h0000_1000, 16'd200, 11'd2, 1'b0, 2);
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 6; n++)
            test_frame($urandom & 32'hFFFF_FFFC, 32'($urandom_range(100, 140)) * 4,
                       16'($urandom_range(1, 100) * 4), 11'($urandom_range(1, 5)),
                       1'($urandom_range(0, 1)), 3);
    endtask

    task automatic test_buf_switch();
        bit got;
        int fd0;
        logic [31:0] ea;
        base0 = 32'h2000_0000; base1 = 32'h3000_0000; stride = 32'h400;
        lbytes = 16'd256; nlines = 11'd3; buf_sel = 1'b0;
        fd0 = fd_cnt;
        pulse_fs();
        for (int i = 0; i < 6; i++) begin
            ea = 32'h2000_0000 + 32'(i / 2) * 32'h400 + 32'(i % 2) * 32'd128;
            wait_req(64, got);
            total++;
            if (!got) begin bad++; $display("FAIL bufsw_req_timeout: burst %0d", i); return; end
            total++;
            if (rd_if.rd_addr !== ea || active_buf !== 1'b0) begin
                bad++;
                $display("FAIL bufsw_burst %0d: addr %h abuf %b want addr %h abuf 0", i, rd_if.rd_addr, active_buf, ea);
            end
            if (i == 1) begin buf_sel = 1'b1; base0 = 32'h4444_0000; end
            serve(0, 1);
        end
        tick(); tick();
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL bufsw_frame_done: got %0d want 1", fd_cnt - fd0); end
        total++; if (active_buf !== 1'b0) begin bad++; $display("FAIL bufsw_abuf_hold: got %b want 0", active_buf); end
        test_frame(32'h3000_0000, 32'h400, 16'd256, 11'd3, 1'b1, 1);
    endtask

    task automatic test_fifo_flow();
        bit seen;
        base0 = 32'h5000_0000; buf_sel = 1'b0; stride = 32'd512; lbytes = 16'd512; nlines = 11'd1;
        fifo_level = 10'd481;
        pulse_fs();
        seen = 1'b0;
        repeat (10) begin tick(); if (rd_if.rd_req) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL fifo_stall_481: rd_req seen %b want 0", seen); end
        fifo_level = 10'd480;
        tick();
        total++;
        if (rd_if.rd_req !== 1'b1 || rd_if.rd_addr !== 32'h5000_0000 || rd_if.rd_len !== 16'd128) begin
            bad++;
            $display("FAIL fifo_room_480: req %b addr %h len %0d want 1 50000000 128",
                     rd_if.rd_req, rd_if.rd_addr, rd_if.rd_len);
        end
        pulse_stop();
        serve(0, 0);
        fifo_level = '0;
        seen = 1'b0;
        repeat (10) begin tick(); if (rd_if.rd_req) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL fifo_halt_idle: rd_req seen %b want 0", seen); end
        pulse_start();
    endtask

    task automatic test_resync();
        bit got, seen;
        int fd0;
        logic [31:0] ea;
        base0 = 32'h6000_0000; buf_sel = 1'b0; stride = 32'h800; lbytes = 16'd256; nlines = 11'd8;
        fd0 = fd_cnt;
        pulse_fs();
        for (int i = 0; i <= 10; i++) begin
            ea = 32'h6000_0000 + 32'(i / 2) * 32'h800 + 32'(i % 2) * 32'd128;
            wait_req(64, got);
            total++;
            if (!got || rd_if.rd_addr !== ea) begin
                bad++;
                $display("FAIL resync_burst %0d: req %b addr %h want 1 %h", i, got, rd_if.rd_addr, ea);
                return;
            end
            if (i < 10) serve(0, 0);
        end
        rd_if.rd_ack = 1'b1; tick(); rd_if.rd_ack = 1'b0;
        pulse_fs();
        total++; if (resync !== 1'b1) begin bad++; $display("FAIL resync_flag: got %b want 1", resync); end
        rd_if.rd_done = 1'b1; tick(); rd_if.rd_done = 1'b0;
        wait_req(64, got);
        total++;
        if (!got || rd_if.rd_addr !== 32'h6000_0000 || rd_if.rd_len !== 16'd128) begin
            bad++;
            $display("FAIL resync_restart: req %b addr %h len %0d want 1 60000000 128", got, rd_if.rd_addr, rd_if.rd_len);
        end
        total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL resync_no_frame_done: got %0d want 0", fd_cnt - fd0); end
        pulse_stop();
        serve(0, 0);
        seen = 1'b0;
        repeat (5) begin tick(); if (rd_if.rd_req) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL resync_halt: rd_req seen %b want 0", seen); end
        pulse_start();
        total++; if (resync !== 1'b0) begin bad++; $display("FAIL resync_clear: got %b want 0", resync); end
    endtask

    task automatic test_stop();
        bit got, seen;
        pulse_stop();
        pulse_fs();
        seen = 1'b0;
        repeat (6) begin tick(); if (rd_if.rd_req) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL stop_armed_idle: rd_req seen %b want 0", seen); end
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        pulse_fs();
        seen = 1'b0;
        repeat (6) begin tick(); if (rd_if.rd_req) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL stop_wins_start: rd_req seen %b want 0", seen); end
        pulse_start();
        pulse_fs();
        wait_req(16, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL stop_rearm_req: rd_req %b want 1", got); end
        pulse_stop();
        total++; if (rd_if.rd_req !== 1'b1) begin bad++; $display("FAIL stop_no_withdraw: rd_req %b want 1", rd_if.rd_req); end
        serve(2, 2);
        seen = 1'b0;
        repeat (8) begin tick(); if (rd_if.rd_req) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL stop_after_burst: rd_req seen %b want 0", seen); end
        pulse_start();
    endtask

    task automatic test_reset_during_req();
        bit got, held;
        base1 = 32'h7000_0000; buf_sel = 1'b1; stride = 32'h400; lbytes = 16'd256; nlines = 11'd4;
        pulse_fs();
        wait_req(16, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL hold_req_start: rd_req %b want 1", got); end
        pulse_fs();
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rd_if.rd_req !== 1'b1 || rd_if.rd_addr !== 32'h7000_0000 || rd_if.rd_len !== 16'd128) held = 1'b0;
            tick();
        end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL hold_req_stable: stable %b want 1", held); end
        total++; if (resync !== 1'b1 || active_buf !== 1'b1) begin
            bad++; $display("FAIL hold_flags: resync %b abuf %b want 1 1", resync, active_buf);
        end
        rst = 1'b1;
        tick();
        total++; if (rd_if.rd_req !== 1'b0) begin bad++; $display("FAIL rstreq_rd_req: got %b want 0", rd_if.rd_req); end
        total++; if (rd_if.rd_addr !== 32'h0 || rd_if.rd_len !== 16'h0) begin
            bad++; $display("FAIL rstreq_addr_len: addr %h len %h want 0 0", rd_if.rd_addr, rd_if.rd_len);
        end
        total++; if (active_buf !== 1'b0 || resync !== 1'b0 || frame_done !== 1'b0) begin
            bad++; $display("FAIL rstreq_flags: abuf %b resync %b fd %b want 0 0 0", active_buf, resync, frame_done);
        end
        rst = 1'b0;
        pulse_fs();
        tick();
        total++; if (rd_if.rd_req !== 1'b0) begin bad++; $display("FAIL rstreq_idle: rd_req %b want 0", rd_if.rd_req); end
    endtask

    initial begin
        rd_if.rd_ack  = 1'b0;
        rd_if.rd_done = 1'b0;
        test_reset();
        pulse_start();
        test_720p();
        test_tail();
        test_random_frames();
        test_buf_switch();
        test_fifo_flow();
        test_resync();
        test_stop();
        test_reset_during_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
